// File: rtl/rotation_line_parser.sv
// Turns an ASCII stream of "R48\nL68\n..." lines into (direction, distance)
// records on a valid/ready output, counting records, bad lines and saturation.
module rotation_line_parser #(
  parameter int DIST_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_direction,
  output logic [DIST_W-1:0] out_distance,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  rec_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              sat_flag
);

  typedef enum logic [1:0] {S_DIR, S_NUM, S_SKIP, S_EMIT} state_t;

  state_t state, state_next;

  logic              dir;
  logic              seen;
  logic [DIST_W-1:0] acc;

  logic              xfer, is_digit, is_dir, is_blank, is_nl, is_cr;
  logic [DIST_W+3:0] prod;
  logic              ovf;
  logic [DIST_W-1:0] acc_dig, emit_val;
  logic              start_line, acc_load, emit, err_inc, rec_inc;

  assign in_ready = (state != S_EMIT);
  assign xfer     = in_valid && in_ready;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_dir   = (in_data == 8'h52) || (in_data == 8'h4C);
  assign is_nl    = (in_data == 8'h0A);
  assign is_cr    = (in_data == 8'h0D);
  assign is_blank = is_nl || is_cr || (in_data == 8'h20);

  // acc*10+d is formed with four bits of headroom so overflow can be detected
  assign prod     = ({4'b0, acc} << 3) + ({4'b0, acc} << 1)
                  + {{DIST_W{1'b0}}, in_data[3:0]};
  assign ovf      = prod > {4'b0, {DIST_W{1'b1}}};
  assign acc_dig  = ovf ? {DIST_W{1'b1}} : prod[DIST_W-1:0];
  assign emit_val = is_digit ? acc_dig : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_DIR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start_line = 1'b0;
    acc_load   = 1'b0;
    emit       = 1'b0;
    err_inc    = 1'b0;
    rec_inc    = 1'b0;
    case (state)
      S_DIR: begin
        if (xfer) begin
          if (is_dir) begin
            start_line = 1'b1;
            if (in_last) err_inc = 1'b1;
            else         state_next = S_NUM;
          end else if (!is_blank) begin
            if (in_last) err_inc = 1'b1;
            else         state_next = S_SKIP;
          end
        end
      end
      S_NUM: begin
        if (xfer) begin
          if (is_digit) begin
            acc_load = 1'b1;
            if (in_last) begin
              emit       = 1'b1;
              state_next = S_EMIT;
            end
          end else if (is_nl || in_last) begin
            // a line terminator (or end of stream) closes the line
            if (seen && (is_nl || is_cr)) begin
              emit       = 1'b1;
              state_next = S_EMIT;
            end else begin
              err_inc    = 1'b1;
              state_next = S_DIR;
            end
          end else if (!is_cr) begin
            state_next = S_SKIP;
          end
        end
      end
      S_SKIP: begin
        if (xfer && (is_nl || in_last)) begin
          err_inc    = 1'b1;
          state_next = S_DIR;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          rec_inc    = 1'b1;
          state_next = S_DIR;
        end
      end
      default: state_next = S_DIR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir           <= 1'b0;
      seen          <= 1'b0;
      acc           <= '0;
      out_valid     <= 1'b0;
      out_direction <= 1'b0;
      out_distance  <= '0;
      rec_count     <= '0;
      err_count     <= '0;
      sat_flag      <= 1'b0;
    end else begin
      if (start_line) begin
        dir  <= (in_data == 8'h52);
        acc  <= '0;
        seen <= 1'b0;
      end
      if (acc_load) begin
        acc  <= acc_dig;
        seen <= 1'b1;
        if (ovf) sat_flag <= 1'b1;
      end
      if (emit) begin
        out_valid     <= 1'b1;
        out_direction <= dir;
        out_distance  <= emit_val;
      end
      if (rec_inc) begin
        out_valid <= 1'b0;
        rec_count <= rec_count + CNT_W'(1);
      end
      if (err_inc) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rotation_line_parser.sv
// Directed bench for rotation_line_parser: a table of byte streams with
// hand-computed records, plus latency, backpressure and mid-line reset cases.
module tb_rotation_line_parser;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic        out_direction;
  logic [15:0] out_distance;
  logic        out_ready;
  logic [15:0] rec_count;
  logic [15:0] err_count;
  logic        sat_flag;

  int checkCount = 0;
  int errCount   = 0;
  int expRec     = 0;
  int expErr     = 0;

  logic [16:0] capQ[$];

  typedef struct {
    logic [127:0] text;
    int           len;
    bit           lastFinal;
    int           nRec;
    bit           expDir;
    logic [15:0]  expDist;
    int           errInc;
    bit           expSat;
  } vec_t;

  vec_t vecs[14];

  rotation_line_parser #(.DIST_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_direction(out_direction), .out_distance(out_distance),
    .out_ready(out_ready), .rec_count(rec_count), .err_count(err_count),
    .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // records are captured on the falling edge ahead of the transferring edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) capQ.push_back({out_direction, out_distance});
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] text, input int len, input bit lastFinal);
    for (int i = len - 1; i >= 0; i--) begin
      bit ok;
      int waits;
      in_valid = 1'b1;
      in_data  = text[8*i +: 8];
      in_last  = lastFinal && (i == 0);
      waits    = 0;
      do begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        waits++;
      end while (!ok && waits < 100);
      if (!ok) checkOutput("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{"X12\nR\nR5\n", 9, 1'b0, 1, 1'b1, 16'd5,     2, 1'b0};
    vecs[1]  = '{"R007\n",       5, 1'b0, 1, 1'b1, 16'd7,     0, 1'b0};
    vecs[2]  = '{"R0\n",         3, 1'b0, 1, 1'b1, 16'd0,     0, 1'b0};
    vecs[3]  = '{"L65535\n",     7, 1'b0, 1, 1'b0, 16'hFFFF,  0, 1'b0};
    vecs[4]  = '{"R99999\n",     7, 1'b0, 1, 1'b1, 16'hFFFF,  0, 1'b1};
    vecs[5]  = '{"L1\n",         3, 1'b0, 1, 1'b0, 16'd1,     0, 1'b1};
    vecs[6]  = '{"R5\r\nL7",     6, 1'b1, 2, 1'b0, 16'd7,     0, 1'b1};
    vecs[7]  = '{"r3\n",         3, 1'b0, 0, 1'b0, 16'd0,     1, 1'b1};
    vecs[8]  = '{" \r\nL12\n",   7, 1'b0, 1, 1'b0, 16'd12,    0, 1'b1};
    vecs[9]  = '{"L\n",          2, 1'b0, 0, 1'b0, 16'd0,     1, 1'b1};
    vecs[10] = '{"R4x\n",        4, 1'b0, 0, 1'b0, 16'd0,     1, 1'b1};
    vecs[11] = '{"R12",          3, 1'b1, 1, 1'b1, 16'd12,    0, 1'b1};
    vecs[12] = '{"R",            1, 1'b1, 0, 1'b0, 16'd0,     1, 1'b1};
    vecs[13] = '{"R3\n",         3, 1'b0, 1, 1'b1, 16'd3,     0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_rec_count", int'(rec_count), 0);
    checkOutput("reset_err_count", int'(err_count), 0);
    checkOutput("reset_sat_flag", int'(sat_flag), 0);
    checkOutput("reset_out_distance", int'(out_distance), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // latency: out_valid rises right after the newline is taken
    capQ.delete();
    applyStimulus("R48", 3, 1'b0);
    checkOutput("lat_before_nl", int'(out_valid), 0);
    applyStimulus("\n", 1, 1'b0);
    checkOutput("lat_valid", int'(out_valid), 1);
    checkOutput("lat_in_ready", int'(in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    expRec = 1;
    checkOutput("lat_nrec", capQ.size(), 1);
    if (capQ.size() > 0) checkOutput("lat_record", int'(capQ[0]), int'({1'b1, 16'd48}));
    checkOutput("lat_rec_count", int'(rec_count), expRec);

    for (int v = 0; v < 14; v++) begin
      capQ.delete();
      applyStimulus(vecs[v].text, vecs[v].len, vecs[v].lastFinal);
      repeat (4) @(posedge clk);
      #1;
      expRec += vecs[v].nRec;
      expErr += vecs[v].errInc;
      checkOutput($sformatf("v%0d_nrec", v), capQ.size(), vecs[v].nRec);
      if (vecs[v].nRec > 0 && capQ.size() > 0) begin
        checkOutput($sformatf("v%0d_dir", v), int'(capQ[$][16]), int'(vecs[v].expDir));
        checkOutput($sformatf("v%0d_dist", v), int'(capQ[$][15:0]), int'(vecs[v].expDist));
      end
      checkOutput($sformatf("v%0d_rec_count", v), int'(rec_count), expRec);
      checkOutput($sformatf("v%0d_err_count", v), int'(err_count), expErr);
      checkOutput($sformatf("v%0d_sat_flag", v), int'(sat_flag), int'(vecs[v].expSat));
    end

    // backpressure: record must hold and input must stall while out_ready is low
    capQ.delete();
    out_ready = 1'b0;
    applyStimulus("L68\n", 4, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d_valid", c), int'(out_valid), 1);
      checkOutput($sformatf("bp%0d_in_ready", c), int'(in_ready), 0);
      checkOutput($sformatf("bp%0d_dir", c), int'(out_direction), 0);
      checkOutput($sformatf("bp%0d_dist", c), int'(out_distance), 68);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    applyStimulus("L30\n", 4, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    expRec += 2;
    checkOutput("bp_nrec", capQ.size(), 2);
    if (capQ.size() == 2) begin
      checkOutput("bp_first", int'(capQ[0]), int'({1'b0, 16'd68}));
      checkOutput("bp_second", int'(capQ[1]), int'({1'b0, 16'd30}));
    end
    checkOutput("bp_rec_count", int'(rec_count), expRec);

    // reset in the middle of a line discards the partial record
    applyStimulus("R4", 2, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_out_valid", int'(out_valid), 0);
    checkOutput("mid_reset_rec_count", int'(rec_count), 0);
    checkOutput("mid_reset_err_count", int'(err_count), 0);
    checkOutput("mid_reset_sat_flag", int'(sat_flag), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    capQ.delete();
    applyStimulus("L3\n", 3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("post_reset_nrec", capQ.size(), 1);
    if (capQ.size() > 0) checkOutput("post_reset_record", int'(capQ[0]), int'({1'b0, 16'd3}));
    checkOutput("post_reset_rec_count", int'(rec_count), 1);
    checkOutput("post_reset_err_count", int'(err_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule
